// File: rtl/bcd_multi_seq.sv
// Multi-digit BCD up/down counter with programmable tick divider and a
// time-multiplexed, active-low 7-segment display driver with leading-zero blanking.
module bcd_multi_seq #(
  parameter int N_DIGITS = 4,
  parameter int TICK_DIV = 100000000,
  parameter int SCAN_DIV = 100000,
  parameter int BLANK_LZ = 1
) (
  input  logic                    clk100M,
  input  logic                    sys_rst,
  input  logic                    en,
  input  logic                    U_D,
  input  logic                    sat,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   load_val,
  input  logic [N_DIGITS-1:0]     dp_in,
  output logic [4*N_DIGITS-1:0]   out,
  output logic                    wrap,
  output logic                    CA,
  output logic                    CB,
  output logic                    CC,
  output logic                    CD,
  output logic                    CE,
  output logic                    CF,
  output logic                    CG,
  output logic                    DP,
  output logic [7:0]              AN
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [4*N_DIGITS-1:0] ALL9 = {N_DIGITS{4'h9}};

  logic [TW-1:0]           r_tick_cnt;
  logic [SW-1:0]           r_scan_cnt;
  logic [2:0]              r_idx;
  logic [4*N_DIGITS-1:0]   r_out;
  logic                    r_wrap;
  logic [7:0]              r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;

  logic                    w_tick;
  logic                    w_scan_tc;
  logic [4*N_DIGITS-1:0]   w_out_next;
  logic                    w_wrap_next;
  logic [3:0]              w_sel_digit;
  logic                    w_sel_dp;
  logic                    w_blank;

  assign w_tick    = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_scan_tc = (r_scan_cnt == SW'(SCAN_DIV - 1));

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Next count: load beats tick; carry/borrow ripples through all digits in one cycle.
  always_comb begin
    logic carry;
    w_out_next  = r_out;
    w_wrap_next = 1'b0;
    carry       = 1'b1;
    if (load) begin
      for (int d = 0; d < N_DIGITS; d++) begin
        w_out_next[4*d +: 4] = (load_val[4*d +: 4] > 4'd9) ? 4'd0 : load_val[4*d +: 4];
      end
    end else if (w_tick && en) begin
      if (U_D) begin
        if (r_out == ALL9) begin
          if (!sat) begin
            w_out_next  = '0;
            w_wrap_next = 1'b1;
          end
        end else begin
          for (int d = 0; d < N_DIGITS; d++) begin
            if (carry) begin
              if (r_out[4*d +: 4] == 4'd9) begin
                w_out_next[4*d +: 4] = 4'd0;
              end else begin
                w_out_next[4*d +: 4] = r_out[4*d +: 4] + 4'd1;
                carry = 1'b0;
              end
            end
          end
        end
      end else begin
        if (r_out == '0) begin
          if (!sat) begin
            w_out_next  = ALL9;
            w_wrap_next = 1'b1;
          end
        end else begin
          for (int d = 0; d < N_DIGITS; d++) begin
            if (carry) begin
              if (r_out[4*d +: 4] == 4'd0) begin
                w_out_next[4*d +: 4] = 4'd9;
              end else begin
                w_out_next[4*d +: 4] = r_out[4*d +: 4] - 4'd1;
                carry = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  // Walk from the top digit down so zero_hi means "this digit and all above are 0".
  always_comb begin
    logic zero_hi;
    w_sel_digit = 4'd0;
    w_sel_dp    = 1'b1;
    w_blank     = 1'b0;
    zero_hi     = 1'b1;
    for (int d = N_DIGITS - 1; d >= 0; d--) begin
      zero_hi = zero_hi && (r_out[4*d +: 4] == 4'd0);
      if (r_idx == 3'(d)) begin
        w_sel_digit = r_out[4*d +: 4];
        w_sel_dp    = ~dp_in[d];
        w_blank     = (BLANK_LZ != 0) && (d != 0) && zero_hi;
      end
    end
  end

  always_ff @(posedge clk100M) begin
    if (sys_rst) begin
      r_tick_cnt <= '0;
      r_scan_cnt <= '0;
      r_idx      <= 3'd0;
      r_out      <= '0;
      r_wrap     <= 1'b0;
      r_an       <= 8'hFF;
      r_seg      <= 7'h7F;
      r_dp       <= 1'b1;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      r_scan_cnt <= w_scan_tc ? '0 : r_scan_cnt + SW'(1);
      if (w_scan_tc) begin
        r_idx <= (r_idx == 3'(N_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
      end
      r_out  <= w_out_next;
      r_wrap <= w_wrap_next;
      r_an   <= ~(8'd1 << r_idx);
      r_seg  <= w_blank ? 7'h7F : seg_decode(w_sel_digit);
      r_dp   <= w_sel_dp;
    end
  end

  assign out  = r_out;
  assign wrap = r_wrap;
  assign {CA, CB, CC, CD, CE, CF, CG} = r_seg;
  assign DP   = r_dp;
  assign AN   = r_an;

endmodule

// File: tb/tb_bcd_multi_seq.sv
// Scoreboard bench for bcd_multi_seq: a decimal-integer model predicts every
// cycle's outputs, a separate monitor pops and compares them after each edge.
module tb_bcd_multi_seq;

  localparam int N  = 3;
  localparam int TD = 4;
  localparam int SD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           sys_rst = 1'b1;
  logic           en = 1'b0, U_D = 1'b1, sat = 1'b0, load = 1'b0;
  logic [4*N-1:0] load_val = '0;
  logic [N-1:0]   dp_in = '0;
  logic [4*N-1:0] out;
  logic           wrap, CA, CB, CC, CD, CE, CF, CG, DP;
  logic [7:0]     AN;

  bcd_multi_seq #(.N_DIGITS(N), .TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(1)) dut (
    .clk100M(clk), .sys_rst(sys_rst), .en(en), .U_D(U_D), .sat(sat), .load(load),
    .load_val(load_val), .dp_in(dp_in), .out(out), .wrap(wrap),
    .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG), .DP(DP), .AN(AN)
  );

  typedef struct {
    logic [4*N-1:0] out;
    logic           wrap;
    logic [7:0]     an;
    logic [6:0]     seg;
    logic           dp;
  } exp_t;

  exp_t q[$];
  int compared   = 0;
  int mismatched = 0;
  int m_val = 0;   // model count as a plain decimal integer
  int m_k   = 0;   // edges since reset released

  function automatic int p10(input int i);
    int r = 1;
    for (int j = 0; j < i; j++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*N-1:0] to_bcd(input int v);
    logic [4*N-1:0] r;
    for (int d = 0; d < N; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int load_dec(input logic [4*N-1:0] lv);
    int v = 0;
    int dig;
    for (int d = N - 1; d >= 0; d--) begin
      dig = int'(lv[4*d +: 4]);
      if (dig > 9) dig = 0;
      v = v * 10 + dig;
    end
    return v;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] t [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    return t[d];
  endfunction

  // Drive one cycle of inputs and predict the state after the coming edge.
  task automatic cycle(input logic rst, input logic e, input logic ud, input logic s,
                       input logic ld, input logic [4*N-1:0] lv, input logic [N-1:0] dp);
    exp_t x;
    int   idx;
    int   maxv;
    @(negedge clk);
    sys_rst = rst; en = e; U_D = ud; sat = s; load = ld; load_val = lv; dp_in = dp;
    maxv = p10(N) - 1;
    if (rst) begin
      m_val = 0; m_k = 0;
      x.out = '0; x.wrap = 1'b0; x.an = 8'hFF; x.seg = 7'h7F; x.dp = 1'b1;
    end else begin
      idx    = (m_k / SD) % N;
      x.an   = 8'hFF;
      x.an[idx] = 1'b0;
      x.seg  = (idx != 0 && (m_val / p10(idx)) == 0) ? 7'h7F : seg_of((m_val / p10(idx)) % 10);
      x.dp   = ~dp[idx];
      x.wrap = 1'b0;
      m_k    = m_k + 1;
      if (ld) begin
        m_val = load_dec(lv);
      end else if ((m_k % TD == 0) && e) begin
        if (ud) begin
          if (m_val == maxv) begin
            if (!s) begin m_val = 0; x.wrap = 1'b1; end
          end else m_val = m_val + 1;
        end else begin
          if (m_val == 0) begin
            if (!s) begin m_val = maxv; x.wrap = 1'b1; end
          end else m_val = m_val - 1;
        end
      end
      x.out = to_bcd(m_val);
    end
    q.push_back(x);
  endtask

  task automatic idle(input int n, input logic e, input logic ud, input logic s, input logic [N-1:0] dp);
    for (int i = 0; i < n; i++) cycle(1'b0, e, ud, s, 1'b0, '0, dp);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every edge presents a new output word; compare it against the model.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("out",  32'(out),  32'(x.out));
        chk("wrap", 32'(wrap), 32'(x.wrap));
        chk("AN",   32'(AN),   32'(x.an));
        chk("seg",  32'({CA, CB, CC, CD, CE, CF, CG}), 32'(x.seg));
        chk("DP",   32'(DP),   32'(x.dp));
      end
    end
  end

  initial begin
    logic [4*N-1:0] lv;
    int pick;

    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(8, 1'b1, 1'b1, 1'b0, '0);
    $display("phase 1: reset and first ticks, model out=%0d", m_val);

    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h999, '0);
    idle(5, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h999, '0);
    idle(6, 1'b1, 1'b1, 1'b1, '0);
    $display("phase 2: up wrap and saturate, model out=%0d", m_val);

    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h100, '0);
    idle(4, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, '0);
    idle(5, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000, '0);
    idle(5, 1'b1, 1'b0, 1'b1, '0);
    $display("phase 3: down borrow, wrap and saturate, model out=%0d", m_val);

    while (((m_k + 1) % TD) != 0) idle(1, 1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h3A7, '0);
    idle(2, 1'b0, 1'b1, 1'b0, '0);
    $display("phase 4: load on tick with invalid digit, model out=%0d", m_val);

    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h042, 3'b010);
    idle(12, 1'b0, 1'b1, 1'b0, 3'b010);
    $display("phase 5: display scan with blanking, model out=%0d", m_val);

    idle(20, 1'b0, 1'b1, 1'b0, 3'b101);
    idle(7, 1'b1, 1'b1, 1'b0, 3'b101);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 3'b101);
    idle(8, 1'b1, 1'b1, 1'b0, 3'b101);
    $display("phase 6: en gating and mid-scan reset, model out=%0d", m_val);

    for (int i = 0; i < 1200; i++) begin
      pick = int'($urandom_range(0, 3));
      case (pick)
        0:       lv = 12'h999;
        1:       lv = 12'h000;
        2:       lv = 12'h001;
        default: lv = 12'($urandom);
      endcase
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            1'($urandom), ($urandom_range(0, 15) == 0), lv, 3'($urandom));
    end
    $display("phase 7: randomized traffic, model out=%0d", m_val);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
